// File: rtl/orbtrace_top_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// orbtrace_top_if
//
// Purpose: bundles the trace capture port, the host UART pins, the status LEDs,
// the debug pins and the flow-control output of orbtrace_top into one
// interface. The signal names match the board-level pin names.
//
// Signals:
//   traceDin[3:0]  trace data nibble, valid around both traceClk edges
//   traceClk       trace clock (oversampled as data by the capture block)
//   uartrx         host UART receive (not used by the capture block)
//   uarttx         host UART transmit, idles high
//   sync_led       TPIU frame sync held
//   rxInd_led      stretched pulse per committed frame
//   txInd_led      stretched while the UART is sending
//   txOvf_led      stretched pulse per dropped frame
//   D6..D3         debug pins
//   cts            FIFO can accept a whole 16-byte frame
//
// Modports:
//   master  the side that drives the trace pins (board / bench)
//   slave   the capture block
// -----------------------------------------------------------------------------
interface orbtrace_top_if;
    logic [3:0] traceDin;
    logic       traceClk;
    logic       uartrx;
    logic       uarttx;
    logic       sync_led;
    logic       rxInd_led;
    logic       txInd_led;
    logic       txOvf_led;
    logic       D6;
    logic       D5;
    logic       D4;
    logic       D3;
    logic       cts;

    modport master (
        output traceDin, traceClk, uartrx,
        input  uarttx, sync_led, rxInd_led, txInd_led, txOvf_led,
        input  D6, D5, D4, D3, cts
    );

    modport slave (
        input  traceDin, traceClk, uartrx,
        output uarttx, sync_led, rxInd_led, txInd_led, txOvf_led,
        output D6, D5, D4, D3, cts
    );
endinterface

// File: rtl/orbtrace_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// orbtrace_top
//
// Purpose: captures a 4-bit DDR parallel TPIU trace port by oversampling it on
// clkIn, finds the TPIU frame sync (bytes FF FF FF 7F), assembles aligned
// 16-byte frames, commits whole frames into a byte FIFO and streams them out
// over an 8N1 UART. Drives status LEDs, debug pins and a flow-control output.
//
// Parameters:
//   CLK_HZ             clkIn frequency
//   BAUD               UART bit rate; CLK_HZ/BAUD must be an integer >= 2
//   FIFO_FRAMES        FIFO depth in 16-byte frames
//   STRETCH_BITS       LED stretch counter width (2^STRETCH_BITS cycles)
//   SYNC_TIMEOUT_BITS  sync is lost after 2^SYNC_TIMEOUT_BITS edgeless cycles
//
// Ports:
//   clkIn             system clock, everything runs on its rising edge
//   rstIn             asynchronous active-high reset
//   inject_pll_clk48  ignored
//   inject_pll_lock   low acts exactly like rstIn
//   bus (slave)       trace inputs, UART, LEDs, debug pins, cts
//
// Build option:
//   ORBTRACE_DEBUG_PINS_EN  when defined, D6 = synchronized traceClk,
//                           D5 = byte strobe, D4 = frame commit strobe,
//                           D3 = UART busy; otherwise D6..D3 are tied low.
// -----------------------------------------------------------------------------
module orbtrace_top #(
    parameter int CLK_HZ            = 48000000,
    parameter int BAUD              = 12000000,
    parameter int FIFO_FRAMES       = 4,
    parameter int STRETCH_BITS      = 16,
    parameter int SYNC_TIMEOUT_BITS = 16
) (
    input  logic           clkIn,
    input  logic           rstIn,
    input  logic           inject_pll_clk48,
    input  logic           inject_pll_lock,
    orbtrace_top_if.slave  bus
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int DEPTH = 16 * FIFO_FRAMES;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RP_W  = $clog2(DEPTH);
    localparam int FP_W  = (FIFO_FRAMES > 1) ? $clog2(FIFO_FRAMES) : 1;
    localparam int BD_W  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [31:0] SYNC_WORD = 32'h7FFF_FFFF;

    // Losing PLL lock holds the block in the same state as the reset pin.
    logic w_rst;
    assign w_rst = rstIn | ~inject_pll_lock;

    // The host receive line and the PLL clock play no part in the design.
    logic w_unused;
    assign w_unused = bus.uartrx ^ inject_pll_clk48;

    // ------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizers, traceClk and traceDin in step
    // ------------------------------------------------------------------
    logic       r_tclk_p0, r_tclk_p1, r_tclk_p2;
    logic [3:0] r_din_p0, r_din_p1;

    always_ff @(posedge clkIn or posedge w_rst) begin
        if (w_rst) begin
            r_tclk_p0 <= 1'b0;
            r_tclk_p1 <= 1'b0;
            r_tclk_p2 <= 1'b0;
            r_din_p0  <= 4'h0;
            r_din_p1  <= 4'h0;
        end else begin
            r_tclk_p0 <= bus.traceClk;
            r_tclk_p1 <= r_tclk_p0;
            r_tclk_p2 <= r_tclk_p1;
            r_din_p0  <= bus.traceDin;
            r_din_p1  <= r_din_p0;
        end
    end

    // Any change of the synchronized clock is a DDR edge carrying one nibble.
    logic w_vld_p1;
    assign w_vld_p1 = r_tclk_p1 ^ r_tclk_p2;

    // ------------------------------------------------------------------
    // Stage p2: sync search, nibble pairing and frame assembly
    // ------------------------------------------------------------------
    logic [31:0]                  r_sr;
    logic                         r_phase;
    logic [3:0]                   r_lo;
    logic [3:0]                   r_idx;
    logic                         r_synced;
    logic [SYNC_TIMEOUT_BITS-1:0] r_to_cnt;
    logic [7:0]                   r_stage [16];

    logic [31:0] w_sr_next;
    logic        w_sync;
    logic        w_byte_stb;
    logic [7:0]  w_byte;
    logic        w_frame_done;
    logic        w_has_room;
    logic        w_commit;
    logic        w_drop;

    // Newest nibble enters at the top, so the oldest of the last eight sits in
    // bits [3:0]; FF FF FF 7F in stream order then reads as 0x7FFFFFFF.
    assign w_sr_next    = {r_din_p1, r_sr[31:4]};
    assign w_sync       = w_vld_p1 && (w_sr_next == SYNC_WORD);
    assign w_byte_stb   = w_vld_p1 && !w_sync && r_synced && r_phase;
    assign w_byte       = {r_din_p1, r_lo};
    assign w_frame_done = w_byte_stb && (r_idx == 4'hF);
    assign w_commit     = w_frame_done && w_has_room;
    assign w_drop       = w_frame_done && !w_has_room;

    always_ff @(posedge clkIn or posedge w_rst) begin
        if (w_rst) begin
            r_sr     <= '0;
            r_phase  <= 1'b0;
            r_lo     <= 4'h0;
            r_idx    <= 4'h0;
            r_synced <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            if (w_vld_p1) begin
                r_sr     <= w_sr_next;
                r_to_cnt <= '0;
                if (w_sync) begin
                    // Realign: the next nibble is the low half of byte 0.
                    r_phase  <= 1'b0;
                    r_idx    <= 4'h0;
                    r_synced <= 1'b1;
                end else begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_lo <= r_din_p1;
                    end
                    if (w_byte_stb) begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
            end else if (r_to_cnt != '1) begin
                r_to_cnt <= r_to_cnt + SYNC_TIMEOUT_BITS'(1);
            end else begin
                r_synced <= 1'b0;
            end
        end
    end

    // Staging buffer holds bytes 0..14; byte 15 is taken straight from the
    // pairing logic in the commit cycle.
    always_ff @(posedge clkIn) begin
        if (w_byte_stb) begin
            r_stage[r_idx] <= w_byte;
        end
    end

    // ------------------------------------------------------------------
    // Stage p3: frame FIFO (whole-frame write, byte read)
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [DEPTH];
    logic [FP_W-1:0]  r_wr_frame;
    logic [RP_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_has_room = (r_count <= CNT_W'(DEPTH - 16));

    always_ff @(posedge clkIn) begin
        if (w_commit) begin
            for (int i = 0; i < 15; i++) begin
                r_mem[{r_wr_frame, 4'(i)}] <= r_stage[i];
            end
            r_mem[{r_wr_frame, 4'hF}] <= w_byte;
        end
    end

    always_ff @(posedge clkIn or posedge w_rst) begin
        if (w_rst) begin
            r_wr_frame <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_commit) begin
                if (r_wr_frame == FP_W'(FIFO_FRAMES - 1)) begin
                    r_wr_frame <= '0;
                end else begin
                    r_wr_frame <= r_wr_frame + FP_W'(1);
                end
            end
            if (w_pop) begin
                if (r_rd_ptr == RP_W'(DEPTH - 1)) begin
                    r_rd_ptr <= '0;
                end else begin
                    r_rd_ptr <= r_rd_ptr + RP_W'(1);
                end
            end
            // A commit and a pop may land in the same cycle.
            unique case ({w_commit, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(16);
                2'b01:   r_count <= r_count - CNT_W'(1);
                2'b11:   r_count <= r_count + CNT_W'(15);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage p4: 8N1 UART transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    uart_state_t     r_ust;
    logic [BD_W-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            w_bit_end;
    logic            w_busy;

    assign w_bit_end = (r_baud == '0);
    assign w_busy    = (r_ust != U_IDLE);
    // Fetch the next byte either from idle or on the last stop-bit cycle, so
    // consecutive bytes run with no idle gap.
    assign w_pop     = (r_count != '0) &&
                       ((r_ust == U_IDLE) || ((r_ust == U_STOP) && w_bit_end));

    always_ff @(posedge clkIn or posedge w_rst) begin
        if (w_rst) begin
            r_ust   <= U_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            unique case (r_ust)
                U_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_baud  <= BD_W'(DIV - 1);
                        r_ust   <= U_START;
                    end
                end
                U_START: begin
                    if (w_bit_end) begin
                        r_tx   <= r_shift[0];
                        r_bit  <= 3'd0;
                        r_baud <= BD_W'(DIV - 1);
                        r_ust  <= U_DATA;
                    end else begin
                        r_baud <= r_baud - BD_W'(1);
                    end
                end
                U_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= BD_W'(DIV - 1);
                        if (r_bit == 3'd7) begin
                            r_tx  <= 1'b1;
                            r_ust <= U_STOP;
                        end else begin
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - BD_W'(1);
                    end
                end
                U_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_tx    <= 1'b0;
                            r_baud  <= BD_W'(DIV - 1);
                            r_ust   <= U_START;
                        end else begin
                            r_ust <= U_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - BD_W'(1);
                    end
                end
                default: r_ust <= U_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage p5: retriggerable LED stretchers (commit, busy, drop)
    // ------------------------------------------------------------------
    logic [2:0]              w_trig;
    logic [STRETCH_BITS-1:0] r_str_cnt [3];
    logic [2:0]              r_led;

    assign w_trig = {w_drop, w_busy, w_commit};

    // Loading all-ones and clearing the LED once the count has run out keeps
    // it lit for exactly 2^STRETCH_BITS cycles after the last trigger.
    always_ff @(posedge clkIn or posedge w_rst) begin
        if (w_rst) begin
            for (int i = 0; i < 3; i++) begin
                r_str_cnt[i] <= '0;
            end
            r_led <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_trig[i]) begin
                    r_str_cnt[i] <= '1;
                    r_led[i]     <= 1'b1;
                end else if (r_str_cnt[i] != '0) begin
                    r_str_cnt[i] <= r_str_cnt[i] - STRETCH_BITS'(1);
                end else begin
                    r_led[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.uarttx    = r_tx;
    assign bus.sync_led  = r_synced;
    assign bus.rxInd_led = r_led[0];
    assign bus.txInd_led = r_led[1];
    assign bus.txOvf_led = r_led[2];
    assign bus.cts       = w_has_room;

`ifdef ORBTRACE_DEBUG_PINS_EN
    assign bus.D6 = r_tclk_p1;
    assign bus.D5 = w_byte_stb;
    assign bus.D4 = w_commit;
    assign bus.D3 = w_busy;
`else
    assign bus.D6 = 1'b0;
    assign bus.D5 = 1'b0;
    assign bus.D4 = 1'b0;
    assign bus.D3 = 1'b0;
`endif

endmodule

// File: tb/tb_orbtrace_top.sv
`timescale 1ns/1ps
module tb_orbtrace_top;

    typedef logic [7:0] u8_t;

    logic clkIn = 1'b0;
    logic rstIn;
    logic pll_clk = 1'b0;
    logic pll_lock;

    orbtrace_top_if bus();

    orbtrace_top #(
        .CLK_HZ(48000000),
        .BAUD(12000000),
        .FIFO_FRAMES(4),
        .STRETCH_BITS(16),
        .SYNC_TIMEOUT_BITS(16)
    ) dut (
        .clkIn(clkIn),
        .rstIn(rstIn),
        .inject_pll_clk48(pll_clk),
        .inject_pll_lock(pll_lock),
        .bus(bus)
    );

    always #10 clkIn = ~clkIn;

    int total = 0;
    int bad   = 0;
    int hp    = 24;
    int gen   = 0;

    u8_t        rx_q[$];
    u8_t        exp_q[$];
    logic [3:0] nib_q[$];
    u8_t        fixed_fr[16] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                                 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    u8_t        unsync_b[8] = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'h66, 8'h99, 8'h66, 8'h99};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One DDR nibble: data leads the clock toggle by hp/2 cycles and is held
    // for the rest of the half period.
    task automatic send_nib(input logic [3:0] n);
        bus.traceDin = n;
        repeat (hp / 2) @(negedge clkIn);
        bus.traceClk = ~bus.traceClk;
        nib_q.push_back(n);
        repeat (hp - hp / 2) @(negedge clkIn);
    endtask

    task automatic send_byte(input u8_t b);
        send_nib(b[3:0]);
        send_nib(b[7:4]);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_byte(8'hFF);
        send_byte(8'h7F);
    endtask

    task automatic send_fixed();
        for (int i = 0; i < 16; i++) send_byte(fixed_fr[i]);
    endtask

    task automatic send_random_frame();
        for (int i = 0; i < 16; i++) send_byte(u8_t'($urandom));
    endtask

    // Stream-level reference: scan every nibble sent since reset, look for the
    // eight-nibble sync pattern, and emit each run of 32 nibbles that follows
    // a sync without being interrupted as a 16-byte frame.
    task automatic build_expected(input int limit);
        int   cnt;
        bit   synced;
        bit   hit;
        logic [3:0] fr[32];
        exp_q.delete();
        cnt = 0;
        synced = 0;
        for (int i = 0; i < nib_q.size(); i++) begin
            hit = (i >= 7) && (nib_q[i] == 4'h7);
            for (int j = 1; j <= 7; j++) begin
                if (i >= 7 && nib_q[i - j] != 4'hF) hit = 0;
            end
            if (hit) begin
                synced = 1;
                cnt = 0;
            end else if (synced) begin
                fr[cnt] = nib_q[i];
                cnt++;
                if (cnt == 32) begin
                    for (int k = 0; k < 16; k++) exp_q.push_back({fr[2 * k + 1], fr[2 * k]});
                    cnt = 0;
                end
            end
        end
        while (limit >= 0 && exp_q.size() > limit) void'(exp_q.pop_back());
    endtask

    task automatic check_rx(input string tag, input int limit);
        int c;
        build_expected(limit);
        c = 0;
        while (rx_q.size() < exp_q.size() && c < 6000) begin
            @(negedge clkIn);
            c++;
        end
        repeat (100) @(negedge clkIn);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    endtask

    task automatic pulse_reset();
        rstIn = 1'b1;
        gen++;
        repeat (3) @(negedge clkIn);
        rstIn = 1'b0;
        nib_q.delete();
        rx_q.delete();
    endtask

    // UART receiver: samples the middle of each 4-cycle bit.
    initial begin
        int   g;
        u8_t  d;
        logic st;
        logic sp;
        forever begin
            @(negedge clkIn);
            if (bus.uarttx === 1'b0) begin
                g = gen;
                repeat (2) @(negedge clkIn);
                st = bus.uarttx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clkIn);
                    d[i] = bus.uarttx;
                end
                repeat (4) @(negedge clkIn);
                sp = bus.uarttx;
                if (g == gen) begin
                    chk("uart_start_bit", st, 1'b0);
                    chk("uart_stop_bit", sp, 1'b1);
                    rx_q.push_back(d);
                end
            end
        end
    end

    initial begin
        int c;
        bus.traceDin = 4'h0;
        bus.traceClk = 1'b0;
        bus.uartrx   = 1'b1;
        pll_lock     = 1'b1;
        rstIn        = 1'b0;
        #1 rstIn     = 1'b1;
        repeat (5) @(negedge clkIn);

        chk("rst_uarttx", bus.uarttx, 1'b1);
        chk("rst_cts", bus.cts, 1'b1);
        chk("rst_sync_led", bus.sync_led, 1'b0);
        chk("rst_leds", {bus.rxInd_led, bus.txInd_led, bus.txOvf_led}, 3'b000);
        chk("rst_dpins", {bus.D6, bus.D5, bus.D4, bus.D3}, 4'h0);
        rstIn = 1'b0;
        nib_q.delete();
        rx_q.delete();

        // Data without any sync must never reach the UART.
        hp = 24;
        for (int i = 0; i < 8; i++) send_byte(unsync_b[i]);
        repeat (200) @(negedge clkIn);
        chk("unsync_sync_led", bus.sync_led, 1'b0);
        check_rx("unsync", -1);

        // Sync followed by two fixed frames.
        hp = $urandom_range(20, 28);
        send_sync();
        send_fixed();
        send_fixed();
        chk("synced_sync_led", bus.sync_led, 1'b1);
        check_rx("synced", -1);
        chk("synced_rxInd", bus.rxInd_led, 1'b1);
        chk("synced_txInd", bus.txInd_led, 1'b1);
        chk("synced_dpins", {bus.D6, bus.D5, bus.D4, bus.D3}, 4'h0);

        // Partial frame cut short by a new sync, then four random frames.
        hp = $urandom_range(20, 28);
        send_sync();
        send_byte(8'h01);
        send_byte(8'h23);
        send_sync();
        for (int f = 0; f < 4; f++) send_random_frame();
        check_rx("interrupted", -1);

        // Reset while the UART is in a start bit.
        hp = $urandom_range(20, 28);
        send_sync();
        send_random_frame();
        c = 0;
        while (bus.uarttx !== 1'b0 && c < 2000) begin
            @(negedge clkIn);
            c++;
        end
        chk("midrst_start_seen", bus.uarttx, 1'b0);
        rstIn = 1'b1;
        gen++;
        #1;
        chk("midrst_uarttx", bus.uarttx, 1'b1);
        chk("midrst_sync_led", bus.sync_led, 1'b0);
        chk("midrst_leds", {bus.rxInd_led, bus.txInd_led, bus.txOvf_led}, 3'b000);
        chk("midrst_cts", bus.cts, 1'b1);
        @(negedge clkIn);
        rstIn = 1'b0;
        nib_q.delete();
        rx_q.delete();
        hp = $urandom_range(20, 28);
        send_sync();
        send_fixed();
        send_fixed();
        check_rx("after_rst", -1);

        // Overflow: frames every 128 cycles against 640 cycles of UART per
        // frame. Frames 1-4 fit (FIFO holds about 38 bytes when frame 4 ends);
        // frame 5 finds about 51 bytes queued, leaving under 16 free.
        pulse_reset();
        hp = 4;
        send_sync();
        for (int f = 0; f < 4; f++) send_random_frame();
        repeat (4) @(negedge clkIn);
        chk("ovf_cts_full", bus.cts, 1'b0);
        chk("ovf_led_before", bus.txOvf_led, 1'b0);
        send_random_frame();
        repeat (4) @(negedge clkIn);
        chk("ovf_led_after", bus.txOvf_led, 1'b1);
        check_rx("overflow", 64);
        chk("ovf_cts_drained", bus.cts, 1'b1);

        // Losing PLL lock behaves like the reset pin.
        chk("pll_pre_sync_led", bus.sync_led, 1'b1);
        pll_lock = 1'b0;
        #1;
        chk("pll_uarttx", bus.uarttx, 1'b1);
        chk("pll_sync_led", bus.sync_led, 1'b0);
        chk("pll_leds", {bus.rxInd_led, bus.txInd_led, bus.txOvf_led}, 3'b000);
        chk("pll_cts", bus.cts, 1'b1);
        repeat (3) @(negedge clkIn);
        pll_lock = 1'b1;
        repeat (3) @(negedge clkIn);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
